// File: rtl/mipsfpga_ahb_gpio_ext_pkg.sv
// Shared word map for the MIPSfpga GPIO slave; the decoder and software headers
// use the same offsets.
package mipsfpga_ahb_gpio_ext_pkg;

    typedef enum logic [3:0] {
        H_GPIO_OUT     = 4'd0,
        H_GPIO_SET     = 4'd1,
        H_GPIO_CLR     = 4'd2,
        H_GPIO_TGL     = 4'd3,
        H_GPIO_IN      = 4'd4,
        H_GPIO_RAW     = 4'd5,
        H_GPIO_RISEEN  = 4'd6,
        H_GPIO_FALLEN  = 4'd7,
        H_GPIO_IRQSTAT = 4'd8,
        H_GPIO_IRQEN   = 4'd9
    } gpio_word_e;

endpackage

// File: rtl/mipsfpga_ahb_gpio_ext_if.sv
// AHB-Lite slave signals used by the GPIO block (no wait states, always OKAY).
interface mipsfpga_ahb_gpio_ext_if;

    logic [5:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (output HADDR, output HWDATA, output HWRITE, output HSEL, input HRDATA);
    modport slave  (input HADDR, input HWDATA, input HWRITE, input HSEL, output HRDATA);

endinterface

// File: rtl/mipsfpga_ahb_gpio_ext_debounce.sv
// Input conditioning: 2-FF synchroniser, then a tick-sampled 3-agree filter.
// With BYPASS set the synchronised value is passed straight through.
module mipsfpga_ahb_gpio_ext_debounce #(
    parameter int unsigned WIDTH  = 1,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] raw_o,
    output logic [WIDTH-1:0] deb_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign raw_o = sync2_q;

    generate
        if (BYPASS) begin : g_bypass
            logic unused_tick;
            assign unused_tick = tick_i;
            assign deb_o       = sync2_q;
        end else begin : g_filter
            logic [WIDTH-1:0] hist0_q;
            logic [WIDTH-1:0] hist1_q;
            logic [WIDTH-1:0] deb_q;
            logic [WIDTH-1:0] deb_d;
            logic [WIDTH-1:0] agree;

            // accept only when the current sample matches both older samples
            assign agree = ~(sync2_q ^ hist0_q) & ~(sync2_q ^ hist1_q);
            assign deb_d = (agree & sync2_q) | (~agree & deb_q);

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    hist0_q <= '0;
                    hist1_q <= '0;
                    deb_q   <= '0;
                end else if (tick_i) begin
                    hist0_q <= sync2_q;
                    hist1_q <= hist0_q;
                    deb_q   <= deb_d;
                end
            end

            assign deb_o = deb_q;
        end
    endgenerate

endmodule

// File: rtl/mipsfpga_ahb_gpio_ext.sv
// GPIO slave: atomic output register, debounced inputs with per-bit edge capture
// and a level interrupt.
module mipsfpga_ahb_gpio_ext
    import mipsfpga_ahb_gpio_ext_pkg::*;
#(
    parameter int unsigned N_IN    = 23,
    parameter int unsigned N_OUT   = 27,
    parameter int unsigned DEB_DIV = 50000
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    mipsfpga_ahb_gpio_ext_if.slave bus,
    input  logic [N_IN-1:0]        IO_IN,
    output logic [N_OUT-1:0]       IO_OUT,
    output logic                   IRQ
);

    logic             tick;
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  deb;
    logic [3:0]       word;
    logic             wr;
    logic [N_OUT-1:0] wd_out;
    logic [N_IN-1:0]  wd_in;
    logic [31:0]      rdata;
    logic             unused_bus;

    logic [N_OUT-1:0] out_q, out_d;
    logic [N_IN-1:0]  rise_en_q, rise_en_d;
    logic [N_IN-1:0]  fall_en_q, fall_en_d;
    logic [N_IN-1:0]  irq_stat_q, irq_stat_d;
    logic [N_IN-1:0]  stat_clr;
    logic             irq_en_q, irq_en_d;
    logic [N_IN-1:0]  deb_dly_q;
    logic             irq_q;

    generate
        if (DEB_DIV > 0) begin : g_presc
            localparam int unsigned   CW   = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEB_DIV - 1);
            logic [CW-1:0] presc_q;

            assign tick = (presc_q == LAST);

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn)  presc_q <= '0;
                else if (tick) presc_q <= '0;
                else           presc_q <= presc_q + 1'b1;
            end
        end else begin : g_no_presc
            assign tick = 1'b0;
        end
    endgenerate

    mipsfpga_ahb_gpio_ext_debounce #(
        .WIDTH  (N_IN),
        .BYPASS (DEB_DIV == 0)
    ) u_debounce (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .tick_i  (tick),
        .pin_i   (IO_IN),
        .raw_o   (raw),
        .deb_o   (deb)
    );

    assign word       = bus.HADDR[5:2];
    assign wr         = bus.HSEL & bus.HWRITE;
    assign wd_out     = bus.HWDATA[N_OUT-1:0];
    assign wd_in      = bus.HWDATA[N_IN-1:0];
    assign unused_bus = &{1'b0, bus.HADDR[1:0], bus.HWDATA};

    always_comb begin
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        stat_clr  = '0;
        if (wr) begin
            case (word)
                H_GPIO_OUT:     out_d     = wd_out;
                H_GPIO_SET:     out_d     = out_q | wd_out;
                H_GPIO_CLR:     out_d     = out_q & ~wd_out;
                H_GPIO_TGL:     out_d     = out_q ^ wd_out;
                H_GPIO_RISEEN:  rise_en_d = wd_in;
                H_GPIO_FALLEN:  fall_en_d = wd_in;
                H_GPIO_IRQSTAT: stat_clr  = wd_in;
                H_GPIO_IRQEN:   irq_en_d  = bus.HWDATA[0];
                default: ;
            endcase
        end
        // a captured edge overrides a same-cycle W1C on that bit
        irq_stat_d = (irq_stat_q & ~stat_clr)
                   | (deb & ~deb_dly_q & rise_en_q)
                   | (~deb & deb_dly_q & fall_en_q);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= 1'b0;
            deb_dly_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            deb_dly_q  <= deb;
            irq_q      <= irq_en_q & (|irq_stat_q);
        end
    end

    always_comb begin
        rdata = '0;
        case (word)
            H_GPIO_OUT:     rdata[N_OUT-1:0] = out_q;
            H_GPIO_IN:      rdata[N_IN-1:0]  = deb;
            H_GPIO_RAW:     rdata[N_IN-1:0]  = raw;
            H_GPIO_RISEEN:  rdata[N_IN-1:0]  = rise_en_q;
            H_GPIO_FALLEN:  rdata[N_IN-1:0]  = fall_en_q;
            H_GPIO_IRQSTAT: rdata[N_IN-1:0]  = irq_stat_q;
            H_GPIO_IRQEN:   rdata[0]         = irq_en_q;
            default: ;
        endcase
    end

    assign bus.HRDATA = rdata;
    assign IO_OUT     = out_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_mipsfpga_ahb_gpio_ext.sv
// Bench for the GPIO slave: a debounced instance (a) and a bypass, narrow instance (b).
module tb_mipsfpga_ahb_gpio_ext;

    localparam logic [31:0] MA_IN  = 32'h007F_FFFF;
    localparam logic [31:0] MA_OUT = 32'h07FF_FFFF;
    localparam logic [31:0] MB_IN  = 32'h0000_001F;
    localparam logic [31:0] MB_OUT = 32'h0000_01FF;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [22:0] pin_a;
    logic [26:0] out_a;
    logic        irq_a;
    logic [4:0]  pin_b;
    logic [8:0]  out_b;
    logic        irq_b;

    int tests_run = 0;
    int tests_failed = 0;

    mipsfpga_ahb_gpio_ext_if a_bus ();
    mipsfpga_ahb_gpio_ext_if b_bus ();

    mipsfpga_ahb_gpio_ext #(.N_IN(23), .N_OUT(27), .DEB_DIV(4)) dut_a (
        .HCLK (HCLK), .HRESETn (HRESETn), .bus (a_bus),
        .IO_IN (pin_a), .IO_OUT (out_a), .IRQ (irq_a)
    );

    mipsfpga_ahb_gpio_ext #(.N_IN(5), .N_OUT(9), .DEB_DIV(0)) dut_b (
        .HCLK (HCLK), .HRESETn (HRESETn), .bus (b_bus),
        .IO_IN (pin_b), .IO_OUT (out_b), .IRQ (irq_b)
    );

    always #5 HCLK = ~HCLK;

    task automatic bus_idle();
        a_bus.HSEL = 1'b0; a_bus.HWRITE = 1'b0;
        b_bus.HSEL = 1'b0; b_bus.HWRITE = 1'b0;
    endtask

    // Drive in the low phase; returns at the negedge after the write edge.
    task automatic bus_wr(input bit sel, input int word, input logic [31:0] data);
        if (sel) begin
            b_bus.HADDR = 6'(word << 2); b_bus.HWDATA = data;
            b_bus.HSEL = 1'b1; b_bus.HWRITE = 1'b1;
        end else begin
            a_bus.HADDR = 6'(word << 2); a_bus.HWDATA = data;
            a_bus.HSEL = 1'b1; a_bus.HWRITE = 1'b1;
        end
        @(negedge HCLK);
        bus_idle();
    endtask

    task automatic bus_rd(input bit sel, input int word, output logic [31:0] data);
        if (sel) b_bus.HADDR = 6'(word << 2);
        else     a_bus.HADDR = 6'(word << 2);
        #1;
        data = sel ? b_bus.HRDATA : a_bus.HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                bus_rd(s[0], w, d);
                tests_run++;
                if (d !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL reset_word dut%0d w%0d: got %h expected 0", s, w, d);
                end
            end
        end
        tests_run++;
        if ({out_a, out_b, irq_a, irq_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_pins: out_a=%h out_b=%h irq_a=%b irq_b=%b expected all 0",
                     out_a, out_b, irq_a, irq_b);
        end
    endtask

    task automatic test_regs_random();
        logic [31:0] m_out [2];
        logic [31:0] m_rise [2];
        logic [31:0] m_fall [2];
        logic        m_irqen [2];
        logic [31:0] mi, mo, d, got, exp;
        int          s, w;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_irqen[i] = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            s  = $urandom_range(0, 1);
            w  = $urandom_range(0, 15);
            d  = $urandom;
            mi = s ? MB_IN : MA_IN;
            mo = s ? MB_OUT : MA_OUT;
            bus_wr(s[0], w, d);
            case (w)
                0: m_out[s] = d & mo;
                1: m_out[s] = m_out[s] | (d & mo);
                2: m_out[s] = m_out[s] & ~d;
                3: m_out[s] = m_out[s] ^ (d & mo);
                6: m_rise[s] = d & mi;
                7: m_fall[s] = d & mi;
                9: m_irqen[s] = d[0];
                default: ;
            endcase
            for (int r = 0; r < 2; r++) begin
                if (r == 1) w = $urandom_range(0, 15);
                case (w)
                    0:       exp = m_out[s];
                    6:       exp = m_rise[s];
                    7:       exp = m_fall[s];
                    9:       exp = {31'b0, m_irqen[s]};
                    default: exp = 0;
                endcase
                bus_rd(s[0], w, got);
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL regs_read dut%0d w%0d: got %h expected %h", s, w, got, exp);
                end
            end
            got = s ? 32'(out_b) : 32'(out_a);
            tests_run++;
            if (got !== m_out[s]) begin
                tests_failed++;
                $display("FAIL regs_io_out dut%0d: got %h expected %h", s, got, m_out[s]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            bus_wr(i[0], 6, 0); bus_wr(i[0], 7, 0); bus_wr(i[0], 9, 0);
        end
    endtask

    task automatic test_atomic_ops();
        logic [31:0] d;
        logic [31:0] exp [3];
        logic [31:0] data [3];
        exp[0] = 32'hFF; exp[1] = 32'hCF; exp[2] = 32'h4E;
        data[0] = 32'h0F; data[1] = 32'h30; data[2] = 32'h81;
        bus_wr(1'b0, 0, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            bus_wr(1'b0, i + 1, data[i]);
            bus_rd(1'b0, 0, d);
            tests_run++;
            if (d !== exp[i]) begin
                tests_failed++;
                $display("FAIL atomic_read op%0d: got %h expected %h", i + 1, d, exp[i]);
            end
            tests_run++;
            if (32'(out_a) !== exp[i]) begin
                tests_failed++;
                $display("FAIL atomic_io_out op%0d: got %h expected %h", i + 1, out_a, exp[i]);
            end
        end
    endtask

    task automatic test_bypass_width();
        logic [31:0] d;
        bus_wr(1'b1, 0, 32'hFFFF_FFFF);
        bus_wr(1'b1, 12, 32'hFFFF_FFFF);
        bus_rd(1'b1, 0, d);
        tests_run++;
        if (d !== 32'h1FF) begin tests_failed++; $display("FAIL width_out: got %h expected 000001ff", d); end
        tests_run++;
        if (out_b !== 9'h1FF) begin tests_failed++; $display("FAIL width_io_out: got %h expected 1ff", out_b); end
        bus_rd(1'b1, 12, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL unmapped_w12: got %h expected 0", d); end
        bus_wr(1'b1, 6, 32'hFFFF_FFFF);
        bus_rd(1'b1, 6, d);
        tests_run++;
        if (d !== 32'h1F) begin tests_failed++; $display("FAIL width_riseen: got %h expected 0000001f", d); end
        bus_wr(1'b1, 6, 0);
        pin_b = 5'h15;
        @(negedge HCLK);
        bus_rd(1'b1, 4, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL bypass_lat1: got %h expected 0", d); end
        @(negedge HCLK);
        bus_rd(1'b1, 4, d);
        tests_run++;
        if (d !== 32'h15) begin tests_failed++; $display("FAIL bypass_lat2: got %h expected 00000015", d); end
        pin_b = 5'h0;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        logic        p1, p2, lvl;
        int          j;
        bit          seen;
        p1 = 1'b0; p2 = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge HCLK);
                bus_rd(1'b0, 5, d);
                tests_run++;
                if (d[0] !== p2) begin
                    tests_failed++;
                    $display("FAIL bounce_raw b%0d c%0d: got %b expected %b", b, c, d[0], p2);
                end
                bus_rd(1'b0, 4, d);
                tests_run++;
                if (d[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bounce_in b%0d c%0d: got %b expected 0", b, c, d[0]);
                end
                lvl = (b % 2 == 0);
                p2 = p1; p1 = lvl;
                pin_a[0] = lvl;
            end
        end
        pin_a[0] = 1'b1;
        j = 0; seen = 0;
        while (!seen && j < 40) begin
            @(negedge HCLK);
            j++;
            bus_rd(1'b0, 4, d);
            seen = d[0];
        end
        tests_run++;
        if (!seen || j < 3 || j > 14) begin
            tests_failed++;
            $display("FAIL deb_latency: got %0d cycles (seen=%0d) expected 3..14", j, seen);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        pin_a = 23'h2;
        repeat (40) @(negedge HCLK);
        bus_wr(1'b0, 6, 32'h1);
        bus_wr(1'b0, 7, 32'h2);
        bus_wr(1'b0, 9, 32'h1);
        bus_wr(1'b0, 8, 32'hFFFF_FFFF);
        repeat (2) @(negedge HCLK);
        bus_rd(1'b0, 8, d);
        tests_run++;
        if (d !== 32'h0 || irq_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL edge_idle: stat=%h irq=%b expected 0/0", d, irq_a);
        end
        pin_a = 23'h1;
        repeat (40) @(negedge HCLK);
        bus_rd(1'b0, 8, d);
        tests_run++;
        if (d !== 32'h3) begin tests_failed++; $display("FAIL edge_stat: got %h expected 00000003", d); end
        tests_run++;
        if (irq_a !== 1'b1) begin tests_failed++; $display("FAIL edge_irq: got %b expected 1", irq_a); end
        bus_wr(1'b0, 8, 32'h1);
        bus_rd(1'b0, 8, d);
        tests_run++;
        if (d !== 32'h2) begin tests_failed++; $display("FAIL edge_w1c_b0: got %h expected 00000002", d); end
        @(negedge HCLK);
        tests_run++;
        if (irq_a !== 1'b1) begin tests_failed++; $display("FAIL edge_irq_held: got %b expected 1", irq_a); end
        bus_wr(1'b0, 8, 32'h2);
        bus_rd(1'b0, 8, d);
        tests_run++;
        if (d !== 32'h0 || irq_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_w1c_b1: stat=%h irq=%b expected 0/1", d, irq_a);
        end
        @(negedge HCLK);
        tests_run++;
        if (irq_a !== 1'b0) begin tests_failed++; $display("FAIL edge_irq_drop: got %b expected 0", irq_a); end
        bus_wr(1'b0, 9, 0);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bus_wr(1'b1, 6, 32'h1);
        bus_wr(1'b1, 8, 32'hFFFF_FFFF);
        pin_b = 5'h1;
        @(negedge HCLK);
        @(negedge HCLK);
        bus_rd(1'b1, 8, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL collide_pre: got %h expected 0", d); end
        b_bus.HADDR = 6'(8 << 2); b_bus.HWDATA = 32'h1;
        b_bus.HSEL = 1'b1; b_bus.HWRITE = 1'b1;
        @(negedge HCLK);
        bus_idle();
        bus_rd(1'b1, 8, d);
        tests_run++;
        if (d[0] !== 1'b1) begin tests_failed++; $display("FAIL collide_set_wins: got %b expected 1", d[0]); end
        bus_wr(1'b1, 8, 32'h1);
        bus_rd(1'b1, 8, d);
        tests_run++;
        if (d !== 32'h0) begin tests_failed++; $display("FAIL collide_clear_after: got %h expected 0", d); end
        bus_wr(1'b1, 6, 0);
        pin_b = 5'h0;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic test_edges_random();
        logic [4:0]  p [0:79];
        logic [4:0]  en_r, en_f, stat_m, edges, clr;
        logic [31:0] d;
        logic        irq_exp;
        en_r = 5'($urandom); en_f = 5'($urandom);
        bus_wr(1'b1, 6, 32'(en_r));
        bus_wr(1'b1, 7, 32'(en_f));
        bus_wr(1'b1, 9, 32'h1);
        p[0] = 5'($urandom);
        for (int i = 1; i < 4; i++) p[i] = p[0];
        pin_b = p[0];
        repeat (5) @(negedge HCLK);
        bus_wr(1'b1, 8, 32'hFFFF_FFFF);
        stat_m = '0; clr = '0;
        for (int k = 4; k < 76; k++) begin
            @(negedge HCLK);
            bus_idle();
            irq_exp = |stat_m;
            edges  = (p[k-3] & ~p[k-4] & en_r) | (~p[k-3] & p[k-4] & en_f);
            stat_m = (stat_m & ~clr) | edges;
            bus_rd(1'b1, 4, d);
            tests_run++;
            if (d !== 32'(p[k-2])) begin
                tests_failed++;
                $display("FAIL rand_in k%0d: got %h expected %h", k, d, p[k-2]);
            end
            bus_rd(1'b1, 8, d);
            tests_run++;
            if (d !== 32'(stat_m)) begin
                tests_failed++;
                $display("FAIL rand_stat k%0d: got %h expected %h", k, d, stat_m);
            end
            tests_run++;
            if (irq_b !== irq_exp) begin
                tests_failed++;
                $display("FAIL rand_irq k%0d: got %b expected %b", k, irq_b, irq_exp);
            end
            p[k] = 5'($urandom);
            pin_b = p[k];
            clr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            if (clr != 0) begin
                b_bus.HADDR = 6'(8 << 2); b_bus.HWDATA = 32'(clr);
                b_bus.HSEL = 1'b1; b_bus.HWRITE = 1'b1;
            end
        end
        @(negedge HCLK);
        bus_idle();
        bus_wr(1'b1, 9, 0);
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        bus_wr(1'b0, 0, 32'h5);
        bus_wr(1'b1, 6, 32'h1F);
        bus_wr(1'b1, 9, 32'h1);
        pin_b = 5'h0;
        repeat (4) @(negedge HCLK);
        pin_b = 5'h1F;
        pin_a = 23'h3;
        repeat (5) @(negedge HCLK);
        bus_rd(1'b1, 8, d);
        tests_run++;
        if (d === 32'h0 || irq_b !== 1'b1 || out_a !== 27'h5) begin
            tests_failed++;
            $display("FAIL midrun_pre: stat=%h irq_b=%b out_a=%h expected nonzero/1/5", d, irq_b, out_a);
        end
        HRESETn = 1'b0;
        #1;
        test_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        bus_rd(1'b1, 4, d);
        tests_run++;
        if (d !== 32'h1F) begin tests_failed++; $display("FAIL post_reset_in: got %h expected 0000001f", d); end
        repeat (2) @(negedge HCLK);
        bus_rd(1'b1, 8, d);
        tests_run++;
        if (d !== 32'h0 || irq_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_masked_rise: stat=%h irq=%b expected 0/0", d, irq_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        a_bus.HADDR = '0; a_bus.HWDATA = '0;
        b_bus.HADDR = '0; b_bus.HWDATA = '0;
        pin_a = '0; pin_b = '0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        test_reset();
        @(negedge HCLK);
        test_regs_random();
        test_atomic_ops();
        test_bypass_width();
        test_debounce();
        test_edge_irq();
        test_collision();
        test_edges_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
